// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame length, common
// mouse command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  // Device falling edges from start of clocking up to the stop bit
  localparam int unsigned PS2_FRAME_FALLS = 10;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // PS/2 parity bit: set when the data byte holds an even number of ones
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one asynchronous PS/2 line: 2-flop synchronizer followed by a
// FILTER_LEN-sample debounce, with a one-cycle falling-edge flag.
// Ports:
//   clk, rst : system clock, async active-high reset (filter resets to 1)
//   line_i   : raw line sample
//   level    : filtered level
//   fall     : one-cycle pulse in the first cycle level reads 0 after a 1
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level,
  output logic fall
);

  localparam int unsigned          CNT_W    = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             fall_q,  fall_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Count consecutive samples that disagree with the accepted level
  always_comb begin
    sync1_d = line_i;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    fall_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts one command byte (LSB first, odd parity, stop) on device clock
// falls and checks the device ack. Lines are driven via pull-low enables.
// Ports:
//   clk, rst                   : system clock, async active-high reset
//   tx_data, tx_start          : byte and single-cycle request (idle only)
//   tx_busy, tx_done, tx_error : status / completion pulses
//   ps2_clk_i, ps2_data_i      : raw bus samples
//   ps2_clk_oe, ps2_data_oe    : 1 pulls the line low
//   rx_hold                    : receiver should ignore the bus
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 13000,
  parameter int unsigned TIMEOUT_CYCLES = 1950000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       rx_hold
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned BIT_W = $clog2(PS2_FRAME_FALLS) + 1;

  // INHIBIT lasts one cycle less than the clock hold: the first REQ cycle
  // keeps ps2_clk low while the start bit is already on data.
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_W-1:0] STOP_FALL = BIT_W'(PS2_FRAME_FALLS - 1);

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0]       shift_q, shift_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             timed;

  logic clk_lvl, clk_fall;
  logic data_lvl, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_i),
    .level  (clk_lvl),
    .fall   (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_data_i),
    .level  (data_lvl),
    .fall   (data_fall_unused)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    timed = (state_q == REQ) || (state_q == SHIFT) ||
            (state_q == ACK) || (state_q == WAIT_IDLE);
    if (timed) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (timed && (to_cnt_q == TO_LAST)) begin
      // Timeout wins over any protocol event in the same cycle
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          if (tx_start && !busy_q) begin
            shift_d   = {odd_parity(tx_data), tx_data};
            inh_cnt_d = '0;
            clk_oe_d  = 1'b1;
            state_d   = INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
          if (inh_cnt_q == INH_LAST) begin
            data_oe_d = 1'b1;
            to_cnt_d  = '0;
            state_d   = REQ;
          end
        end
        REQ: begin
          clk_oe_d  = 1'b0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (clk_fall) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == STOP_FALL) begin
              data_oe_d = 1'b0;
              state_d   = ACK;
            end else begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[8:1]};
            end
          end
        end
        ACK: begin
          if (clk_fall) begin
            if (!data_lvl) begin
              state_d = WAIT_IDLE;
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_lvl && data_lvl) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_busy     = busy_q;
  assign rx_hold     = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector bus with a behavioural PS/2
// device that clocks frames, samples bits on its rising edges and acks.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 20;
  localparam int unsigned TMO  = 4000;
  localparam int unsigned FLEN = 2;
  localparam int          HALF = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_i, ps2_data_i;
  logic       ps2_clk_oe, ps2_data_oe, rx_hold;
  logic       dev_clk_low, dev_data_low;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int both_seen = 0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .rx_hold     (rx_hold)
  );

  // Count high cycles of each completion pulse
  always @(negedge clk) begin
    if (tx_done === 1'b1)  done_seen <= done_seen + 1;
    if (tx_error === 1'b1) err_seen  <= err_seen + 1;
    if (tx_done === 1'b1 && tx_error === 1'b1) both_seen <= both_seen + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bits the device should see: start 0, d0..d7, parity (1 when even ones), stop 1
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, 1'((ones % 2) == 0), b, 1'b0};
  endfunction

  task automatic run_frame(input logic [7:0] b, input bit ack, input int poke_at,
                           input int rst_at, output logic [10:0] got, output int low,
                           output int err_lat, output int done_lat,
                           output logic hold_mid, output bit aborted);
    int n;
    got = '0; low = 0; err_lat = -1; done_lat = -1; hold_mid = 1'b0; aborted = 1'b0;
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (ps2_clk_oe === 1'b1 && low < 1000) begin low++; @(negedge clk); end
    got[0]   = ps2_data_i;
    hold_mid = tx_busy & rx_hold;
    for (int k = 1; k <= 10; k++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      if (k == rst_at) begin
        repeat (8) @(negedge clk);
        aborted = 1'b1;
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      got[k] = ps2_data_i;
      if (k == poke_at) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    end
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    for (int i = 0; i < HALF; i++) begin
      @(negedge clk);
      if (err_lat < 0 && tx_error === 1'b1) err_lat = i;
    end
    dev_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_lat < 0 && tx_done === 1'b1) done_lat = i;
    end
  endtask

  task automatic xfer_ok(input logic [7:0] b, input int poke_at, input string tag);
    logic [10:0] got;
    int          low, el, dl, d0, e0;
    logic        hm;
    bit          ab;
    d0 = done_seen;
    e0 = err_seen;
    run_frame(b, 1'b1, poke_at, 0, got, low, el, dl, hm, ab);
    repeat (5) @(negedge clk);
    chk({tag, "_frame"}, 32'(got), 32'(exp_frame(b)));
    chk({tag, "_inhibit_len"}, 32'(low), INH);
    chk({tag, "_busy_hold"}, 32'(hm), 32'd1);
    chk({tag, "_done_lat"}, 32'(dl >= 1 && dl <= 15), 32'd1);
    chk({tag, "_done_cnt"}, 32'(done_seen - d0), 32'd1);
    chk({tag, "_err_cnt"}, 32'(err_seen - e0), 32'd0);
    chk({tag, "_idle"}, 32'({tx_busy, rx_hold, ps2_clk_oe, ps2_data_oe}), 32'd0);
  endtask

  initial begin
    logic [10:0] got;
    int          low, el, dl, d0, e0, n;
    logic        hm;
    bit          ab;

    rst = 1'b0; tx_data = '0; tx_start = 1'b0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_outputs", 32'({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe, rx_hold}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Enable reporting and parity corner bytes
    xfer_ok(CMD_ENABLE, 0, "enable");
    xfer_ok(CMD_RESET, 0, "reset_cmd");
    xfer_ok(8'h00, 0, "zero");

    // Device does not ack
    d0 = done_seen; e0 = err_seen;
    run_frame(8'($urandom), 1'b0, 0, 0, got, low, el, dl, hm, ab);
    chk("noack_err_lat", 32'(el >= 1 && el <= 10), 32'd1);
    chk("noack_err_cnt", 32'(err_seen - e0), 32'd1);
    chk("noack_done_cnt", 32'(done_seen - d0), 32'd0);
    chk("noack_idle", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'd0);

    // Silent device: timeout counted from request-to-send
    e0 = err_seen;
    @(negedge clk);
    tx_data = 8'($urandom); tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    n = 0;
    while (ps2_data_oe !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("silent_req", 32'(ps2_data_oe), 32'd1);
    n = 0;
    while (tx_error !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    chk("silent_tmo_cycles", 32'(n), TMO);
    chk("silent_released", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'd0);
    @(negedge clk);
    chk("silent_err_pulse", 32'(tx_error), 32'd0);
    chk("silent_err_cnt", 32'(err_seen - e0), 32'd1);
    repeat (5) @(negedge clk);

    // Start request while busy must not disturb the frame
    xfer_ok(8'($urandom), 4, "busy_start");
    repeat (50) @(negedge clk);
    chk("busy_start_no_retx", 32'({tx_busy, ps2_clk_oe}), 32'd0);

    // Asynchronous reset mid-frame
    run_frame(CMD_ENABLE, 1'b1, 0, 4, got, low, el, dl, hm, ab);
    chk("rst_mid_aborted", 32'(ab), 32'd1);
    chk("rst_mid_pre_data", 32'(ps2_data_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_released", 32'({tx_busy, ps2_clk_oe, ps2_data_oe}), 32'd0);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    xfer_ok(CMD_ENABLE, 0, "after_rst");

    // Random bytes
    for (int i = 0; i < 3; i++) xfer_ok(8'($urandom), 0, $sformatf("rand%0d", i));

    chk("never_done_and_error", 32'(both_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
